// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues sequential PC reads to a one-cycle instruction
// memory and buffers returned words in a 2-entry FIFO with redirect/flush support.
module fetch_unit #(
   parameter int IW       = 8,
   parameter int AW       = 8,
   parameter int RESET_PC = 0
) (
   input  logic          clk,
   input  logic          rst_n,
   output logic          imem_req,
   output logic [AW-1:0] imem_addr,
   input  logic [IW-1:0] imem_rdata,
   output logic [IW-1:0] instr,
   output logic [AW-1:0] instr_pc,
   output logic          instr_valid,
   input  logic          instr_ready,
   input  logic          redirect_valid,
   input  logic [AW-1:0] redirect_pc
);

   localparam logic [AW-1:0] RST_PC = AW'(RESET_PC);

   logic [AW-1:0] pc;
   logic          inflight;
   logic [AW-1:0] req_pc_p1;
   logic [1:0]    count;
   logic          wr_ptr;
   logic          rd_ptr;
   logic [IW-1:0] buf_instr [2];
   logic [AW-1:0] buf_pc    [2];

   logic          pop;
   logic          push;
   logic [2:0]    occupancy;

   assign instr_valid = (count != 2'd0);
   assign pop         = instr_valid & instr_ready;
   assign push        = inflight & ~redirect_valid;

   // Slots committed after this cycle: buffered + in flight - leaving now.
   assign occupancy = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};

   // Gated by rst_n so no request escapes while reset is held.
   assign imem_req  = rst_n & ~redirect_valid & (occupancy < 3'd2);
   assign imem_addr = pc;

   assign instr    = instr_valid ? buf_instr[rd_ptr] : '0;
   assign instr_pc = instr_valid ? buf_pc[rd_ptr]    : '0;

   // Stage p0 -> p1: request issue and FIFO control
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc       <= RST_PC;
         inflight <= 1'b0;
         count    <= 2'd0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
      end else if (redirect_valid) begin
         pc       <= redirect_pc;
         inflight <= 1'b0;
         count    <= 2'd0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
      end else begin
         inflight <= imem_req;
         if (imem_req) pc <= pc + 1'b1;
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

   // Stage p1 -> p2: capture returned word with the address it was fetched from
   always_ff @(posedge clk) begin
      if (imem_req) req_pc_p1 <= pc;
      if (push) begin
         buf_instr[wr_ptr] <= imem_rdata;
         buf_pc[wr_ptr]    <= req_pc_p1;
      end
   end

endmodule
